// File: rtl/bcd_counter_nd.sv
// bcd_counter_nd: N-digit BCD up/down counter with synchronous load, wrap/tc/err flags and 7-segment outputs.
// Build option: define BCD_CNT_SAT_EN to saturate at all-9s / all-0s instead of wrapping.
module bcd_counter_nd #(
  parameter int DIGITS = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                up_i,
  input  logic                load_i,
  input  logic [4*DIGITS-1:0] load_val_i,
  input  logic                blank_lz_i,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic [7*DIGITS-1:0] seg_o,
  output logic                tc_o,
  output logic                wrap_o,
  output logic                err_o
);

  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                wrap_q, wrap_d;
  logic                err_q, err_d;
  logic                carry_s;
  logic                lz_s;
  logic                all9_s, all0_s;
  logic [6:0]          pat_s;

  // Pattern is returned as abcdefg with segment a in the MSB.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  // Next-state: load sanitises nibbles, a step ripples a carry/borrow from digit 0 upward.
  always_comb begin
    bcd_d   = bcd_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    carry_s = 1'b0;
    if (load_i) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (load_val_i[4*i +: 4] > 4'd9) begin
          bcd_d[4*i +: 4] = 4'd0;
          err_d           = 1'b1;
        end else begin
          bcd_d[4*i +: 4] = load_val_i[4*i +: 4];
        end
      end
    end else if (en_i) begin
      carry_s = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        if (carry_s) begin
          if (up_i) begin
            if (bcd_q[4*i +: 4] == 4'd9) begin
              bcd_d[4*i +: 4] = 4'd0;
            end else begin
              bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
              carry_s         = 1'b0;
            end
          end else begin
            if (bcd_q[4*i +: 4] == 4'd0) begin
              bcd_d[4*i +: 4] = 4'd9;
            end else begin
              bcd_d[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
              carry_s         = 1'b0;
            end
          end
        end else begin
          bcd_d[4*i +: 4] = bcd_q[4*i +: 4];
        end
      end
      // A carry out of the top digit means the whole counter rolled over.
`ifdef BCD_CNT_SAT_EN
      if (carry_s) begin
        bcd_d = bcd_q;
      end else begin
        wrap_d = 1'b0;
      end
`else
      wrap_d = carry_s;
`endif
    end else begin
      bcd_d = bcd_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bcd_q  <= {(4*DIGITS){1'b0}};
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  // Segment decode, scanning from the top digit so lz_s tracks "this and all higher digits are 0".
  always_comb begin
    seg_o = {(7*DIGITS){1'b0}};
    lz_s  = 1'b1;
    pat_s = 7'b0000000;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_s = lz_s & (bcd_q[4*i +: 4] == 4'd0);
      if (blank_lz_i && (i != 0) && lz_s) begin
        pat_s = 7'b0000000;
      end else begin
        pat_s = seg7(bcd_q[4*i +: 4]);
      end
      for (int k = 0; k < 7; k++) begin
        seg_o[7*i + k] = pat_s[6 - k];
      end
    end
  end

  // Terminal-count detection.
  always_comb begin
    all9_s = 1'b1;
    all0_s = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      all9_s = all9_s & (bcd_q[4*i +: 4] == 4'd9);
      all0_s = all0_s & (bcd_q[4*i +: 4] == 4'd0);
    end
  end

  assign tc_o   = up_i ? all9_s : all0_s;
  assign bcd_o  = bcd_q;
  assign wrap_o = wrap_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_bcd_counter_nd.sv
// Self-checking bench for bcd_counter_nd (DIGITS=3): directed scenarios plus random stimulus
// compared against an integer-valued reference model.
module tb_bcd_counter_nd;
  localparam int D    = 3;
  localparam int MAXV = 999;

  logic           clk = 1'b0;
  logic           rst, en, up, load, blank;
  logic [4*D-1:0] lv;
  logic [4*D-1:0] bcd;
  logic [7*D-1:0] seg;
  logic           tc, wrap, err;

  int n_checks = 0;
  int n_errors = 0;
  int mv;
  bit mwrap, merr;
  logic [6:0] tbl [0:9];

  bcd_counter_nd #(.DIGITS(D)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .load_i(load),
    .load_val_i(lv), .blank_lz_i(blank), .bcd_o(bcd), .seg_o(seg),
    .tc_o(tc), .wrap_o(wrap), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pow10(input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r = '0;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [7*D-1:0] exp_seg(input int v, input logic bl);
    logic [7*D-1:0] r = '0;
    logic [6:0] p;
    for (int i = 0; i < D; i++) begin
      p = tbl[(v / pow10(i)) % 10];
      if (bl && i > 0 && v < pow10(i)) p = 7'b0000000;
      for (int k = 0; k < 7; k++) r[7*i + k] = p[6 - k];
    end
    return r;
  endfunction

  // abcdefg pattern of digit i as seen on the pins
  function automatic logic [6:0] dig(input int i);
    logic [6:0] p;
    for (int k = 0; k < 7; k++) p[6 - k] = seg[7*i + k];
    return p;
  endfunction

  task automatic model_step(input logic e, input logic u, input logic l, input logic [4*D-1:0] val);
    mwrap = 1'b0;
    merr  = 1'b0;
    if (l) begin
      mv = 0;
      for (int i = 0; i < D; i++) begin
        if (val[4*i +: 4] > 4'd9) merr = 1'b1;
        else mv += int'(val[4*i +: 4]) * pow10(i);
      end
    end else if (e) begin
      if (u) begin
        if (mv == MAXV) begin
`ifdef BCD_CNT_SAT_EN
          mv = MAXV;
`else
          mv = 0; mwrap = 1'b1;
`endif
        end else mv = mv + 1;
      end else begin
        if (mv == 0) begin
`ifdef BCD_CNT_SAT_EN
          mv = 0;
`else
          mv = MAXV; mwrap = 1'b1;
`endif
        end else mv = mv - 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".bcd"}, 32'(bcd), 32'(to_bcd(mv)));
    check({tag, ".seg"}, 32'(seg), 32'(exp_seg(mv, blank)));
    check({tag, ".tc"}, 32'(tc), 32'(up ? (mv == MAXV) : (mv == 0)));
    check({tag, ".wrap"}, 32'(wrap), 32'(mwrap));
    check({tag, ".err"}, 32'(err), 32'(merr));
  endtask

  // Drive at negedge, clock once, check at the following negedge.
  task automatic cycle(input string tag, input logic e, input logic u, input logic l,
                       input logic [4*D-1:0] val, input logic bl);
    en = e; up = u; load = l; lv = val; blank = bl;
    @(posedge clk);
    model_step(e, u, l, val);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    tbl[0] = 7'b1111110; tbl[1] = 7'b0110000; tbl[2] = 7'b1101101; tbl[3] = 7'b1111001;
    tbl[4] = 7'b0110011; tbl[5] = 7'b1011011; tbl[6] = 7'b1011111; tbl[7] = 7'b1110000;
    tbl[8] = 7'b1111111; tbl[9] = 7'b1111011;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; lv = '0; blank = 1'b0;
    mv = 0; mwrap = 1'b0; merr = 1'b0;
    @(negedge clk);
    check_all("reset");
    blank = 1'b1; #1;
    check_all("reset_blank");
    up = 1'b0; #1;
    check("reset_tc_down", 32'(tc), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // count up 12 steps
    for (int i = 0; i < 12; i++) cycle("count", 1'b1, 1'b1, 1'b0, '0, 1'b0);
    check("count12", 32'(bcd), 32'h012);
    check("count12_seg0", 32'(dig(0)), 32'(7'b1101101));

    // up wrap
    cycle("ld998", 1'b0, 1'b1, 1'b1, 12'h998, 1'b0);
    cycle("up999", 1'b1, 1'b1, 1'b0, '0, 1'b0);
    check("up999_tc", 32'(tc), 32'd1);
    cycle("upwrap", 1'b1, 1'b1, 1'b0, '0, 1'b0);
`ifdef BCD_CNT_SAT_EN
    check("upsat_bcd", 32'(bcd), 32'h999);
    check("upsat_wrap", 32'(wrap), 32'd0);
`else
    check("upwrap_bcd", 32'(bcd), 32'h000);
    check("upwrap_wrap", 32'(wrap), 32'd1);
`endif
    cycle("idle", 1'b0, 1'b1, 1'b0, '0, 1'b0);
    check("wrap_pulse_end", 32'(wrap), 32'd0);

    // down borrow and down wrap
    cycle("ld100", 1'b0, 1'b0, 1'b1, 12'h100, 1'b0);
    cycle("dn099", 1'b1, 1'b0, 1'b0, '0, 1'b0);
    check("borrow", 32'(bcd), 32'h099);
    cycle("ld000", 1'b0, 1'b0, 1'b1, 12'h000, 1'b0);
    cycle("dnwrap", 1'b1, 1'b0, 1'b0, '0, 1'b0);
`ifdef BCD_CNT_SAT_EN
    check("dnsat_bcd", 32'(bcd), 32'h000);
`else
    check("dnwrap_bcd", 32'(bcd), 32'h999);
    check("dnwrap_wrap", 32'(wrap), 32'd1);
`endif

    // invalid load, then load beats enable
    cycle("ld5A7", 1'b0, 1'b1, 1'b1, 12'h5A7, 1'b0);
    check("inv_bcd", 32'(bcd), 32'h507);
    check("inv_err", 32'(err), 32'd1);
    cycle("idle2", 1'b0, 1'b1, 1'b0, '0, 1'b0);
    check("err_pulse_end", 32'(err), 32'd0);
    cycle("ld_en", 1'b1, 1'b1, 1'b1, 12'h123, 1'b0);
    check("load_wins", 32'(bcd), 32'h123);

    // blanking
    cycle("ld007", 1'b0, 1'b1, 1'b1, 12'h007, 1'b1);
    check("bl007_d2", 32'(dig(2)), 32'd0);
    check("bl007_d1", 32'(dig(1)), 32'd0);
    check("bl007_d0", 32'(dig(0)), 32'(7'b1110000));
    cycle("ld070", 1'b0, 1'b1, 1'b1, 12'h070, 1'b1);
    check("bl070_d2", 32'(dig(2)), 32'd0);
    check("bl070_d1", 32'(dig(1)), 32'(7'b1110000));
    check("bl070_d0", 32'(dig(0)), 32'(7'b1111110));

    // async reset mid-count
    cycle("ld345", 1'b0, 1'b1, 1'b1, 12'h345, 1'b0);
    en = 1'b1; up = 1'b1; load = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_bcd", 32'(bcd), 32'h000);
    mv = 0; mwrap = 1'b0; merr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("rst_hold");
    rst = 1'b0;
    cycle("resume", 1'b1, 1'b1, 1'b0, '0, 1'b0);
    check("resume_bcd", 32'(bcd), 32'h001);

    // random traffic, biased toward the wrap boundaries
    for (int n = 0; n < 3000; n++) begin
      logic [4*D-1:0] v;
      logic l;
      l = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       v = 12'h999;
        1:       v = 12'h000;
        default: v = 12'($urandom);
      endcase
      cycle("rand", ($urandom_range(0, 3) != 0), 1'($urandom), l, v, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bcd_counter_nd.md
# bcd_counter_nd

Parametrised N-digit BCD up/down counter with synchronous load, wrap/terminal-count flags and per-digit 7-segment outputs. It is the general successor to the fixed 3-digit display counter: digit count is a parameter, and direction, load, enable and leading-zero blanking are runtime controls. It sits between the control logic and the display pins, and feeds `wrap` to a further counter stage when cascaded.

## Interface

Parameters:
- `DIGITS`, 3, number of BCD digits (1..8); digit 0 is least significant.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  count enable; one step per cycle while high.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `load`  in  1  synchronous load of `load_val`.
- `load_val`  in  4*DIGITS  BCD value to load; nibble i is digit i.
- `blank_lz`  in  1  leading-zero blanking for the segment outputs.
- `bcd`  out  4*DIGITS  registered count; nibble i is digit i.
- `seg`  out  7*DIGITS  segments, active-high; `seg[7*i+0..7*i+6]` = a..g of digit i.
- `tc`  out  1  terminal count: all digits 9 when `up`=1, all digits 0 when `up`=0 (combinational from `bcd` and `up`).
- `wrap`  out  1  registered one-cycle pulse on the step that wraps.
- `err`  out  1  registered one-cycle pulse when a load contained an invalid nibble.

## Operation

- Priority per cycle: `rst` > `load` > `en`. With `en`=0 and `load`=0, all registers hold.
- Load: each nibble of `load_val` greater than 9 is stored as 0. `err` is 1 on the next cycle if any nibble was invalid, else 0. `wrap` is 0 on a load cycle.
- Up step: digit 0 increments. Digit i increments only when digits 0..i-1 are all 9. A digit at 9 that steps goes to 0.
- Down step: digit 0 decrements. Digit i decrements only when digits 0..i-1 are all 0. A digit at 0 that steps goes to 9.
- Wrap: an up step from all-9s gives all-0s, and a down step from all-0s gives all-9s. `wrap` is 1 for exactly the following cycle.
- Changing `up` while `en`=1 takes effect on the same edge. There is no pipeline.
- Segment decode per digit (a..g, active-high):
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011
- Blanking: when `blank_lz`=1, every digit i>0 that is 0 and has all higher digits 0 outputs 0000000. Digit 0 is never blanked.

## Timing

- Reset values (asynchronous, immediate): `bcd`=0, `wrap`=0, `err`=0.
  - `seg` then shows "0" on every digit, or only on digit 0 when `blank_lz`=1.
  - `tc` = `~up`.
- Latency:
  - `bcd` updates one cycle after `en`/`load` is sampled.
  - `wrap` and `err` are valid in the same cycle as the updated `bcd`.
  - `seg` and `tc` are combinational from `bcd` and the inputs, with zero added latency.
- Cascading: drive the next stage's `en` from this stage's `tc & en`, not from `wrap`, to avoid a one-cycle skew.
- `rst` asserted mid-count clears everything immediately. Counting resumes on the first rising edge after `rst` deasserts.

## Configuration

- `BCD_CNT_SAT_EN` defined:
  - Saturating mode. An up step at all-9s and a down step at all-0s hold the value.
  - `wrap` stays 0. `tc` behaves the same as in wrap mode.
- `BCD_CNT_SAT_EN` undefined: wrap-around mode as described in Operation.

## Test plan

(All scenarios use `DIGITS`=3.)
- Reset and count: `rst` pulse, then `en`=1, `up`=1 for 12 cycles -> `bcd`=0x012 and `seg` digit 0 = 1101101; `wrap` never asserts.
- Up wrap: load 0x998, then `en`=1, `up`=1 for 2 cycles -> `bcd` goes 0x999 (`tc`=1), then 0x000 with `wrap`=1 for one cycle. With `BCD_CNT_SAT_EN` defined: holds 0x999 and `wrap`=0.
- Down borrow: load 0x100, then `up`=0 for 1 step -> `bcd`=0x099. Load 0x000 and step down -> `bcd`=0x999 and `wrap`=1.
- Invalid load: `load_val`=0x5A7 -> `bcd`=0x507 and `err`=1 for exactly one cycle. Simultaneous `load` and `en`: the load wins.
- Blanking: load 0x007 with `blank_lz`=1 -> digits 2 and 1 show 0000000, digit 0 shows 1110000. Load 0x070 -> only digit 2 is blanked.
- Reset mid-count: assert `rst` asynchronously at `bcd`=0x345 between edges -> `bcd`=0x000 immediately, with no further change until `rst` deasserts.
